mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipelined datapath's instruction-fetch port (PCF/InstrF side) and its data port (ALUResultM/WriteDataM/ReadDataM side).
- Serializes requests through a 3-state FSM with a wait-state counter.
- Returns per-port ready pulses and stall outputs that feed the hazard unit (StallF, and a MEM-stage stall).

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port and the data port,
// serializing accesses with round-robin arbitration on contention and a fixed wait-state count.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall_f,
   output logic              stall_m,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
   end
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              last_d_q, last_d_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic              grant_d;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d_d  = last_d_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      i_ready_d = 1'b0;
      d_ready_d = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      // on contention D wins unless it won the previous contention
      grant_d   = d_req & (~i_req | ~last_d_q);
      if (state_q == IDLE) begin
         if (i_req | d_req) begin
            state_d = grant_d ? BUSY_D : BUSY_I;
            cnt_d   = WAIT_CNT;
            addr_d  = grant_d ? d_addr : i_addr;
            we_d    = grant_d & d_we;
            wdata_d = grant_d ? d_wdata : '0;
            if (i_req & d_req) last_d_d = grant_d;
         end
      end else begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = IDLE;
            if (state_q == BUSY_I) begin
               i_ready_d = 1'b1;
               i_rdata_d = mem_rdata;
            end else begin
               d_ready_d = 1'b1;
               if (!we_q) d_rdata_d = mem_rdata;
            end
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_d_q  <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_d_q  <= last_d_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end
   assign mem_en    = state_q != IDLE;
   assign mem_we    = state_q == BUSY_D && we_q;
   assign mem_addr  = mem_en ? addr_q : '0;
   assign mem_wdata = mem_we ? wdata_q : '0;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall_f   = i_req & ~i_ready_q;
   assign stall_m   = d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus checked each cycle against a
// transaction-level model of the arbiter; a second WAIT_CYCLES=1 instance checks fetch cadence.
module tb_mem_port_arbiter;
   logic        clk = 1'b0, reset;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_ready, d_ready, stall_f, stall_m, mem_en, mem_we;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_req1;
   logic [31:0] mem_rdata1;
   logic        i_ready1, d_ready1, stall_f1, stall_m1, mem_en1, mem_we1;
   logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
   int          n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata), .stall_f(stall_f), .stall_m(stall_m),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .i_req(i_req1), .i_addr(32'h40), .i_ready(i_ready1), .i_rdata(i_rdata1),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ready(d_ready1), .d_rdata(d_rdata1), .stall_f(stall_f1), .stall_m(stall_m1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1));
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
   endtask
   // model: one transaction in flight (remaining cycles, port 0=I 1=D), plus per-port results
   int          m_rem;
   bit          m_port, m_we, m_last, m_ir, m_dr;
   logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
   bit          grants[$];
   task automatic model_reset();
      m_rem = 0; m_port = 0; m_we = 0; m_last = 0; m_ir = 0; m_dr = 0;
      m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
   endtask
   task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] md);
      bit busy, st, g, nir, ndr;
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; mem_rdata = md;
      #1;
      busy = m_rem > 0;
      st = busy && m_port && m_we;
      check("mem_en", mem_en, busy);
      check("mem_we", mem_we, st);
      check("mem_addr", mem_addr, busy ? m_addr : 32'h0);
      check("mem_wdata", mem_wdata, st ? m_wdata : 32'h0);
      check("i_ready", i_ready, m_ir);
      check("d_ready", d_ready, m_dr);
      check("i_rdata", i_rdata, m_irdata);
      check("d_rdata", d_rdata, m_drdata);
      check("stall_f", stall_f, ir && !m_ir);
      check("stall_m", stall_m, dr && !m_dr);
      @(posedge clk);
      nir = 0; ndr = 0;
      if (busy) begin
         if (m_rem == 1) begin
            if (!m_port) begin m_irdata = md; nir = 1; end
            else begin ndr = 1; if (!m_we) m_drdata = md; end
         end
         m_rem--;
      end else if (ir || dr) begin
         if (ir && dr) begin g = !m_last; m_last = g; end
         else g = dr;
         grants.push_back(g);
         m_port = g; m_rem = 2;
         m_addr = g ? da : ia;
         m_we = g && dw;
         m_wdata = dwd;
      end
      m_ir = nir; m_dr = ndr;
      #1;
   endtask
   task automatic full_reset();
      reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_req1 = 0;
      @(posedge clk); #1;
      model_reset();
      reset = 1'b0;
   endtask
   initial begin
      reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
      mem_rdata = 0; i_req1 = 0; mem_rdata1 = 0;
      #12;
      check("rst_outs", {i_ready, d_ready, stall_f, stall_m, mem_en, mem_we}, 6'b0);
      check("rst_data", {i_rdata, d_rdata, mem_addr, mem_wdata}, 128'h0);
      check("rst_outs1", {i_ready1, d_ready1, stall_f1, stall_m1, mem_en1, mem_we1}, 6'b0);
      check("rst_data1", {i_rdata1, d_rdata1, mem_addr1, mem_wdata1}, 128'h0);
      full_reset();
      // fetch of 0x10
      step(1, 32'h10, 0, 0, 0, 0, 32'h0);
      step(1, 32'h10, 0, 0, 0, 0, 32'h0);
      step(1, 32'h10, 0, 0, 0, 0, 32'hE3A00001);
      check("fetch_ready", i_ready, 1'b1);
      check("fetch_rdata", i_rdata, 32'hE3A00001);
      step(0, 32'h0, 0, 0, 0, 0, 32'h0);
      // store 7 to 0x64
      step(0, 0, 1, 1, 32'h64, 32'h7, 32'h0);
      check("store_we", mem_we, 1'b1);
      check("store_wdata", mem_wdata, 32'h7);
      step(0, 0, 1, 1, 32'h64, 32'h7, 32'h0);
      step(0, 0, 1, 1, 32'h64, 32'h7, 32'h55);
      check("store_ready", d_ready, 1'b1);
      check("store_rdata", d_rdata, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0);
      // contention from reset: D, I, D, I
      full_reset();
      grants.delete();
      for (int k = 0; k < 13; k++) step(1, 32'h100 + k, 1, 0, 32'h200 + k, 0, $urandom);
      check("grant_cnt", grants.size(), 5);
      for (int k = 0; k < 4; k++) check("grant_order", grants[k], (k % 2) == 0);
      // load 0x20 with fetch raised mid-transaction
      full_reset();
      step(0, 0, 1, 0, 32'h20, 0, 0);
      step(1, 32'h30, 1, 0, 32'h20, 0, 0);
      step(1, 32'h30, 1, 0, 32'h20, 0, 32'hDEADBEEF);
      check("load_rdata", d_rdata, 32'hDEADBEEF);
      step(1, 32'h30, 0, 0, 0, 0, 0);
      step(1, 32'h30, 0, 0, 0, 0, 0);
      step(1, 32'h30, 0, 0, 0, 0, 32'hCAFE0001);
      check("late_fetch", {i_ready, i_rdata}, {1'b1, 32'hCAFE0001});
      step(0, 0, 0, 0, 0, 0, 0);
      // reset in the first BUSY_I cycle
      step(1, 32'h44, 0, 0, 0, 0, 0);
      check("pre_rst_en", mem_en, 1'b1);
      reset = 1'b1; #1;
      check("rst_mid_en", {mem_en, mem_we}, 2'b0);
      full_reset();
      step(0, 0, 0, 0, 0, 0, 32'h1234);
      check("rst_no_ready", i_ready, 1'b0);
      step(1, 32'h44, 0, 0, 0, 0, 0);
      step(1, 32'h44, 0, 0, 0, 0, 0);
      step(0, 32'h44, 0, 0, 0, 0, 32'h600D);
      check("reissue", {i_ready, i_rdata}, {1'b1, 32'h600D});
      // random traffic
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
              $urandom, $urandom, $urandom);
      // WAIT_CYCLES=1 instance: one fetch every second cycle
      full_reset();
      i_req1 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         mem_rdata1 = 32'h100 + k;
         #1;
         check("w1_en", mem_en1, (k % 2) == 1);
         check("w1_ready", i_ready1, k >= 2 && (k % 2) == 0);
         if (k >= 2 && (k % 2) == 0) check("w1_rdata", i_rdata1, 32'h100 + k - 1);
         step(0, 0, 0, 0, 0, 0, 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
